int_ctrl: RTL and testbench

Interrupt controller that sits between the four external interrupt request lines and the CPU control unit. It latches request edges into a pending register, selects the highest-priority eligible request, and presents a single request plus a 10-bit handler vector to the CPU. It completes a req/ack handshake and tracks in-service levels so that nested interrupts and the return-from-interrupt (reti) path work together with the return-address stack.

---
 rtl/int_pkg.sv | 26 ++
 rtl/prio_enc4.sv | 22 ++
 rtl/int_ctrl.sv | 119 +++++++++++
 tb/tb_int_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/int_pkg.sv
// Shared constants for the interrupt controller: line count, vector defaults,
// and the request FSM encoding.
package int_pkg;

    localparam int NINT  = 4;
    localparam int VEC_W = 10;

    localparam logic [VEC_W-1:0] VEC0_DEF = 10'b1111111011;
    localparam logic [VEC_W-1:0] VEC1_DEF = 10'b1111111110;
    localparam logic [VEC_W-1:0] VEC2_DEF = 10'b1111111101;
    localparam logic [VEC_W-1:0] VEC3_DEF = 10'b1111111100;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    // Lines strictly above the given level; with no level active every line qualifies.
    function automatic logic [NINT-1:0] above_level(input logic [1:0] idx, input logic valid);
        logic [NINT-1:0] m;
        m = 4'b1111;
        if (valid) begin
            m = (4'b0001 << idx) - 4'b0001;
        end
        return m;
    endfunction

endpackage

// File: rtl/prio_enc4.sv
// Four-input priority encoder, bit 0 wins; valid flags any bit set.
module prio_enc4 (
    input  logic [3:0] req,
    output logic [1:0] idx,
    output logic       valid
);

    always_comb begin
        valid = |req;
        idx   = 2'd0;
        if (req[0]) begin
            idx = 2'd0;
        end else if (req[1]) begin
            idx = 2'd1;
        end else if (req[2]) begin
            idx = 2'd2;
        end else if (req[3]) begin
            idx = 2'd3;
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Four-line nested interrupt controller: edge capture, priority selection,
// and a frozen req/ack handshake towards the CPU with reti unwinding.
//
// state   | meaning
// IDLE    | no request presented; picks the best eligible line
// REQ     | int_req/int_vec held for the latched line until ack
module int_ctrl
    import int_pkg::*;
#(
    parameter int               VEC_W = 10,
    parameter logic [VEC_W-1:0] VEC0  = 10'b1111111011,
    parameter logic [VEC_W-1:0] VEC1  = 10'b1111111110,
    parameter logic [VEC_W-1:0] VEC2  = 10'b1111111101,
    parameter logic [VEC_W-1:0] VEC3  = 10'b1111111100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       irq_in,
    input  logic [3:0]       ie,
    input  logic             ack,
    input  logic             reti,
    output logic             int_req,
    output logic [VEC_W-1:0] int_vec,
    output logic [3:0]       pending,
    output logic [3:0]       in_service
);

    logic [0:0]       state_q, state_d;
    logic [3:0]       irq_q, irq_d;
    logic [3:0]       pending_q, pending_d;
    logic [3:0]       in_service_q, in_service_d;
    logic [1:0]       sel_q, sel_d;
    logic [VEC_W-1:0] int_vec_q, int_vec_d;

    logic [3:0] rise;
    logic [3:0] eligible;
    logic [1:0] isr_idx, elig_idx;
    logic       isr_valid, elig_valid;

    prio_enc4 u_isr_enc (
        .req   (in_service_q),
        .idx   (isr_idx),
        .valid (isr_valid)
    );

    prio_enc4 u_elig_enc (
        .req   (eligible),
        .idx   (elig_idx),
        .valid (elig_valid)
    );

    function automatic logic [VEC_W-1:0] vec_of(input logic [1:0] idx);
        logic [VEC_W-1:0] v;
        case (idx)
            2'd0:    v = VEC0;
            2'd1:    v = VEC1;
            2'd2:    v = VEC2;
            default: v = VEC3;
        endcase
        return v;
    endfunction

    assign rise     = irq_in & ~irq_q;
    assign eligible = pending_q & ie & above_level(isr_idx, isr_valid);

    always_comb begin
        irq_d        = irq_in;
        pending_d    = pending_q;
        in_service_d = in_service_q;
        state_d      = state_q;
        sel_d        = sel_q;
        int_vec_d    = int_vec_q;

        if (reti && isr_valid) begin
            in_service_d[isr_idx] = 1'b0;
        end

        if (state_q == ST_IDLE) begin
            if (elig_valid) begin
                state_d   = ST_REQ;
                sel_d     = elig_idx;
                int_vec_d = vec_of(elig_idx);
            end
        end else if (ack) begin
            pending_d[sel_q]    = 1'b0;
            in_service_d[sel_q] = 1'b1;
            state_d             = ST_IDLE;
            int_vec_d           = '0;
        end

        // A fresh edge outranks the ack clear of the same line.
        pending_d = pending_d | rise;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            // Track the live level during reset so a line already high at release is not an edge.
            irq_q        <= irq_in;
            pending_q    <= '0;
            in_service_q <= '0;
            sel_q        <= 2'd0;
            int_vec_q    <= '0;
        end else begin
            state_q      <= state_d;
            irq_q        <= irq_d;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            sel_q        <= sel_d;
            int_vec_q    <= int_vec_d;
        end
    end

    assign int_req    = (state_q == ST_REQ);
    assign int_vec    = int_vec_q;
    assign pending    = pending_q;
    assign in_service = in_service_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural model of the interrupt rules.
module tb_int_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq_in;
    logic [3:0] ie;
    logic       ack;
    logic       reti;
    logic       int_req;
    logic [9:0] int_vec;
    logic [3:0] pending;
    logic [3:0] in_service;

    int n_chk = 0;
    int n_err = 0;

    logic [9:0] vtab [4];

    // Model state: requests awaiting ack, active levels, presented line.
    bit         m_pend [4];
    bit         m_isr  [4];
    bit         m_prev [4];
    bit         m_req;
    int         m_sel;

    int_ctrl u_dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .ie         (ie),
        .ack        (ack),
        .reti       (reti),
        .int_req    (int_req),
        .int_vec    (int_vec),
        .pending    (pending),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [3:0] pack(input bit b [4]);
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = b[i];
        return v;
    endfunction

    task automatic model_edge(input logic r, input logic [3:0] irq, input logic [3:0] en,
                              input logic a, input logic rt);
        int  top;
        int  best;
        bit  edge_seen [4];
        if (!r) begin
            for (int i = 0; i < 4; i++) begin
                m_pend[i] = 0;
                m_isr[i]  = 0;
                m_prev[i] = irq[i];
            end
            m_req = 0;
            m_sel = 0;
            return;
        end
        for (int i = 0; i < 4; i++) edge_seen[i] = irq[i] && !m_prev[i];
        top = 4;
        for (int i = 3; i >= 0; i--) if (m_isr[i]) top = i;
        best = -1;
        for (int i = 3; i >= 0; i--) if (i < top && m_pend[i] && en[i]) best = i;
        if (rt && top < 4) m_isr[top] = 0;
        if (!m_req) begin
            if (best >= 0) begin
                m_req = 1;
                m_sel = best;
            end
        end else if (a) begin
            m_pend[m_sel] = 0;
            m_isr[m_sel]  = 1;
            m_req         = 0;
        end
        for (int i = 0; i < 4; i++) begin
            if (edge_seen[i]) m_pend[i] = 1;
            m_prev[i] = irq[i];
        end
    endtask

    task automatic cyc(input logic r, input logic [3:0] irq, input logic [3:0] en,
                       input logic a, input logic rt);
        reset  = r;
        irq_in = irq;
        ie     = en;
        ack    = a;
        reti   = rt;
        @(posedge clk);
        model_edge(r, irq, en, a, rt);
        #1;
        check("int_req", {31'd0, int_req}, {31'd0, m_req});
        check("pending", {28'd0, pending}, {28'd0, pack(m_pend)});
        check("in_service", {28'd0, in_service}, {28'd0, pack(m_isr)});
        if (m_req) check("int_vec", {22'd0, int_vec}, {22'd0, vtab[m_sel]});
    endtask

    initial begin
        logic       r, a, rt;
        logic [3:0] irq, en;

        vtab[0] = 10'b1111111011;
        vtab[1] = 10'b1111111110;
        vtab[2] = 10'b1111111101;
        vtab[3] = 10'b1111111100;
        m_req = 0;
        m_sel = 0;
        for (int i = 0; i < 4; i++) begin
            m_pend[i] = 0;
            m_isr[i]  = 0;
            m_prev[i] = 0;
        end

        // Reset with lines held high, then release: no edge.
        cyc(0, 4'hF, 4'hF, 0, 0);
        cyc(0, 4'hF, 4'hF, 0, 0);
        check("rst_int_req", {31'd0, int_req}, 32'd0);
        check("rst_int_vec", {22'd0, int_vec}, 32'd0);
        check("rst_pending", {28'd0, pending}, 32'd0);
        cyc(1, 4'hF, 4'hF, 0, 0);
        cyc(1, 4'hF, 4'hF, 0, 0);
        cyc(1, 4'hF, 4'hF, 0, 0);
        check("rel_int_req", {31'd0, int_req}, 32'd0);
        check("rel_pending", {28'd0, pending}, 32'd0);
        cyc(1, 4'h0, 4'hF, 0, 0);

        // Single interrupt on line 2.
        cyc(1, 4'b0100, 4'hF, 0, 0);
        check("single_pend", {28'd0, pending}, 32'b0100);
        check("single_noreq", {31'd0, int_req}, 32'd0);
        cyc(1, 4'b0000, 4'hF, 0, 0);
        check("single_req", {31'd0, int_req}, 32'd1);
        check("single_vec", {22'd0, int_vec}, 32'b1111111101);
        cyc(1, 4'b0000, 4'hF, 1, 0);
        check("single_ack_pend", {28'd0, pending}, 32'd0);
        check("single_ack_isr", {28'd0, in_service}, 32'b0100);
        check("single_ack_req", {31'd0, int_req}, 32'd0);
        cyc(1, 4'b0000, 4'hF, 0, 1);
        check("single_reti", {28'd0, in_service}, 32'd0);

        // Priority between lines 3 and 1.
        cyc(1, 4'b1010, 4'hF, 0, 0);
        cyc(1, 4'b0000, 4'hF, 0, 0);
        check("prio_vec", {22'd0, int_vec}, 32'b1111111110);
        cyc(1, 4'b0000, 4'hF, 1, 0);
        cyc(1, 4'b0000, 4'hF, 0, 0);
        cyc(1, 4'b0000, 4'hF, 0, 0);
        check("prio_blocked", {31'd0, int_req}, 32'd0);
        cyc(1, 4'b0000, 4'hF, 0, 1);
        cyc(1, 4'b0000, 4'hF, 0, 0);
        check("prio_l3_req", {31'd0, int_req}, 32'd1);
        check("prio_l3_vec", {22'd0, int_vec}, 32'b1111111100);
        cyc(1, 4'b0000, 4'hF, 1, 0);
        cyc(1, 4'b0000, 4'hF, 0, 1);

        // Nesting: line 0 preempts line 2.
        cyc(1, 4'b0100, 4'hF, 0, 0);
        cyc(1, 4'b0000, 4'hF, 0, 0);
        cyc(1, 4'b0000, 4'hF, 1, 0);
        cyc(1, 4'b0001, 4'hF, 0, 0);
        cyc(1, 4'b0000, 4'hF, 0, 0);
        check("nest_vec", {22'd0, int_vec}, 32'b1111111011);
        cyc(1, 4'b0000, 4'hF, 1, 0);
        check("nest_isr", {28'd0, in_service}, 32'b0101);
        cyc(1, 4'b0000, 4'hF, 0, 1);
        check("nest_reti1", {28'd0, in_service}, 32'b0100);
        cyc(1, 4'b0000, 4'hF, 0, 1);
        check("nest_reti2", {28'd0, in_service}, 32'b0000);

        // Mask and freeze.
        cyc(1, 4'b0010, 4'h0, 0, 0);
        check("mask_pend", {28'd0, pending}, 32'b0010);
        cyc(1, 4'b0000, 4'h0, 0, 0);
        cyc(1, 4'b0000, 4'h0, 0, 0);
        check("mask_noreq", {31'd0, int_req}, 32'd0);
        cyc(1, 4'b0000, 4'b0010, 0, 0);
        check("mask_en_req", {31'd0, int_req}, 32'd1);
        cyc(1, 4'b0000, 4'h0, 0, 0);
        cyc(1, 4'b0000, 4'h0, 0, 0);
        check("freeze_req", {31'd0, int_req}, 32'd1);
        cyc(1, 4'b0000, 4'h0, 1, 0);
        check("freeze_ack", {28'd0, in_service}, 32'b0010);
        cyc(1, 4'b0000, 4'hF, 0, 1);

        // Edge on the line being acked keeps it pending.
        cyc(1, 4'b0100, 4'hF, 0, 0);
        cyc(1, 4'b0000, 4'hF, 0, 0);
        cyc(1, 4'b0100, 4'hF, 1, 0);
        check("setack_pend", {28'd0, pending}, 32'b0100);
        check("setack_isr", {28'd0, in_service}, 32'b0100);
        cyc(1, 4'b0000, 4'hF, 0, 1);
        cyc(1, 4'b0000, 4'hF, 0, 0);
        check("setack_rereq", {31'd0, int_req}, 32'd1);
        cyc(1, 4'b0000, 4'hF, 1, 0);
        cyc(1, 4'b0000, 4'hF, 0, 1);

        // Boundaries: ack in IDLE, reti with nothing in service, reset in REQ.
        cyc(1, 4'b0000, 4'hF, 1, 0);
        check("idle_ack_isr", {28'd0, in_service}, 32'd0);
        check("idle_ack_req", {31'd0, int_req}, 32'd0);
        cyc(1, 4'b0000, 4'hF, 0, 1);
        check("empty_reti", {28'd0, in_service}, 32'd0);
        cyc(1, 4'b0001, 4'hF, 0, 0);
        cyc(1, 4'b0000, 4'hF, 0, 0);
        check("pre_rst_req", {31'd0, int_req}, 32'd1);
        cyc(0, 4'b0000, 4'hF, 0, 0);
        check("midrst_req", {31'd0, int_req}, 32'd0);
        check("midrst_pend", {28'd0, pending}, 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            r   = ($urandom_range(0, 99) != 0);
            irq = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            en  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            a   = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            rt  = ($urandom_range(0, 5) == 0);
            cyc(r, irq, en, a, rt);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
